// File: rtl/my_chip.sv
// my_chip: bit-serial multiply-accumulate with a 12-bit pin interface.
// Define SYNC_INPUTS_EN to route io_in[11:7] through a 2-flop synchronizer.
module my_chip #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int NUM_MACS  = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int MW = $clog2(NUM_MACS + 1);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_WAIT, S_DONE} state_t;
    state_t state;
    logic [4:0] ctl;
    logic start, shift_a, shift_b, shift, do_next, shift_d, shift_rise;
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] product, partial;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0] sum;
    logic carry, end_mul, finish;
    logic [CW-1:0] bit_cnt;
    logic [MW-1:0] mac_cnt;
    logic unused_io;
`ifdef SYNC_INPUTS_EN
    logic [4:0] sync_1, sync_2;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= io_in[11:7];
            sync_2 <= sync_1;
        end
    assign ctl = sync_2;
`else
    assign ctl = io_in[11:7];
`endif
    assign unused_io = ^io_in[6:0];
    assign {start, shift_a, shift_b, shift, do_next} = ctl;
    assign shift_rise = shift & ~shift_d;
    always_comb begin
        partial = b[bit_cnt[IW-1:0]] ? ({{WIDTH{1'b0}}, a} << bit_cnt) : '0;
        sum = {1'b0, acc} + (ACC_WIDTH+1)'(product);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            a       <= '0;
            b       <= '0;
            product <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            mac_cnt <= '0;
            shift_d <= 1'b0;
            end_mul <= 1'b0;
            finish  <= 1'b0;
        end else begin
            shift_d <= shift;
            if (start) begin
                state   <= S_LOAD;
                acc     <= '0;
                carry   <= 1'b0;
                bit_cnt <= '0;
                mac_cnt <= '0;
                end_mul <= 1'b0;
                finish  <= 1'b0;
            end else begin
                case (state)
                    S_LOAD:
                        if (shift_rise) begin
                            a       <= {a[WIDTH-2:0], shift_a};
                            b       <= {b[WIDTH-2:0], shift_b};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CW'(WIDTH - 1)) begin
                                state   <= S_MUL;
                                product <= '0;
                                bit_cnt <= '0;
                            end
                        end
                    S_MUL:
                        // WIDTH shift-add cycles, then one cycle to fold the product in
                        if (bit_cnt == CW'(WIDTH)) begin
                            acc     <= sum[ACC_WIDTH-1:0];
                            carry   <= carry | sum[ACC_WIDTH];
                            mac_cnt <= mac_cnt + 1'b1;
                            if (mac_cnt == MW'(NUM_MACS - 1)) begin
                                state  <= S_DONE;
                                finish <= 1'b1;
                            end else begin
                                state   <= S_WAIT;
                                end_mul <= 1'b1;
                            end
                        end else begin
                            product <= product + partial;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    S_WAIT:
                        if (do_next) begin
                            state   <= S_LOAD;
                            bit_cnt <= '0;
                            end_mul <= 1'b0;
                        end
                    S_DONE:
                        if (shift_rise)
                            acc <= acc >> 1;
                    default: ;
                endcase
            end
        end
    end
    assign io_out = {carry, finish, finish & acc[0], end_mul, 8'b0};
endmodule

// File: tb/tb_my_chip.sv
// tb_my_chip: scoreboard bench for my_chip; three instances cover the default,
// single-product and narrow-accumulator configurations on a shared pin bus.
module tb_my_chip;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 0, sa = 0, sb = 0, sh = 0, dn = 0;
    logic [6:0] junk = '0;
    logic [11:0] io_in, out0, out1, out2;
    int n_cmp = 0, n_bad = 0;
    bit exp_q[$];
`ifdef SYNC_INPUTS_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 10;
`endif
    assign io_in = {start, sa, sb, sh, dn, junk};
    always #5 clock = ~clock;

    my_chip dut0 (.clock(clock), .reset(reset), .io_in(io_in), .io_out(out0));
    my_chip #(.NUM_MACS(1)) dut1 (.clock(clock), .reset(reset), .io_in(io_in), .io_out(out1));
    my_chip #(.ACC_WIDTH(16)) dut2 (.clock(clock), .reset(reset), .io_in(io_in), .io_out(out2));

    function automatic logic [11:0] obs(input int s);
        return s == 0 ? out0 : s == 1 ? out1 : out2;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
        junk = 7'($urandom);
    endtask
    task automatic do_reset;
        reset = 1;
        {start, sa, sb, sh, dn} = '0;
        repeat (2) tick;
        reset = 0;
        tick;
    endtask
    task automatic pulse_start;
        start = 1; tick; start = 0; tick;
    endtask
    task automatic pulse_next;
        dn = 1; tick; dn = 0; tick;
    endtask
    task automatic pulse_shift;
        sh = 1; tick; tick; sh = 0; repeat (3) tick;
    endtask
    task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sa = a[i]; sb = b[i];
            pulse_shift;
        end
        sa = 0; sb = 0;
    endtask
    task automatic wait_flag(input int s, input int bt, output int cyc);
        cyc = 0;
        while (!obs(s)[bt] && cyc < 80) begin
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) tick;
        n_cmp++; if (out0 !== 12'h0) begin n_bad++; $display("FAIL reset_out0 got %h want 000", out0); end
        n_cmp++; if (out1 !== 12'h0) begin n_bad++; $display("FAIL reset_out1 got %h want 000", out1); end
        n_cmp++; if (out2 !== 12'h0) begin n_bad++; $display("FAIL reset_out2 got %h want 000", out2); end
        reset = 0;
        tick;
        send_bits(8'hFF, 8'hFF, 8);
        pulse_next;
        repeat (12) tick;
        n_cmp++; if (out0 !== 12'h0) begin n_bad++; $display("FAIL idle_ignore_out0 got %h want 000", out0); end
        n_cmp++; if (out1 !== 12'h0) begin n_bad++; $display("FAIL idle_ignore_out1 got %h want 000", out1); end
    endtask

    task automatic test_full_run;
        int cyc, exp;
        bit e;
        do_reset;
        pulse_start;
        exp = 0;
        for (int i = 0; i < 9; i++) begin
            send_bits(8'(i + 2), 8'(i + 3), 8);
            exp += (i + 2) * (i + 3);
            wait_flag(0, i < 8 ? 8 : 10, cyc);
            if (i < 8) begin
                n_cmp++; if (out0[8] !== 1'b1) begin n_bad++; $display("FAIL end_mul_%0d got %b want 1", i, out0[8]); end
                n_cmp++; if (out0[10] !== 1'b0) begin n_bad++; $display("FAIL early_finish_%0d got %b want 0", i, out0[10]); end
                if (i == 0) begin
                    n_cmp++; if (cyc + 5 != LAT) begin n_bad++; $display("FAIL end_mul_latency got %0d want %0d", cyc + 5, LAT); end
                end
                pulse_next;
                if (i == 0) begin
                    n_cmp++; if (out0[8] !== 1'b0) begin n_bad++; $display("FAIL end_mul_clear got %b want 0", out0[8]); end
                end
            end
        end
        n_cmp++; if (out0[10] !== 1'b1) begin n_bad++; $display("FAIL finish got %b want 1", out0[10]); end
        n_cmp++; if (out0[11] !== 1'b0) begin n_bad++; $display("FAIL full_carry got %b want 0", out0[11]); end
        n_cmp++; if (out0[8] !== 1'b0) begin n_bad++; $display("FAIL end_mul_in_done got %b want 0", out0[8]); end
        for (int k = 0; k < 20; k++) exp_q.push_back(exp[k]);
        for (int k = 0; k < 20; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out0[9] !== e) begin n_bad++; $display("FAIL full_bit%0d got %b want %b", k, out0[9], e); end
            pulse_shift;
        end
        pulse_shift;
        n_cmp++; if (out0[9] !== 1'b0) begin n_bad++; $display("FAIL full_drained got %b want 0", out0[9]); end
        n_cmp++; if (out0[10] !== 1'b1) begin n_bad++; $display("FAIL finish_hold got %b want 1", out0[10]); end
    endtask

    task automatic test_single;
        int cyc, exp;
        bit e;
        do_reset;
        pulse_start;
        send_bits(8'd255, 8'd255, 8);
        wait_flag(1, 10, cyc);
        exp = 65025;
        n_cmp++; if (out1[10] !== 1'b1) begin n_bad++; $display("FAIL single_finish got %b want 1", out1[10]); end
        n_cmp++; if (cyc + 5 != LAT) begin n_bad++; $display("FAIL finish_latency got %0d want %0d", cyc + 5, LAT); end
        n_cmp++; if (out1[11] !== 1'b0) begin n_bad++; $display("FAIL single_carry got %b want 0", out1[11]); end
        for (int k = 0; k < 20; k++) exp_q.push_back(exp[k]);
        for (int k = 0; k < 20; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out1[9] !== e) begin n_bad++; $display("FAIL single_bit%0d got %b want %b", k, out1[9], e); end
            pulse_shift;
        end
    endtask

    task automatic test_overflow;
        int cyc, exp;
        bit e;
        do_reset;
        pulse_start;
        for (int i = 0; i < 9; i++) begin
            send_bits(8'd255, 8'd255, 8);
            wait_flag(2, i < 8 ? 8 : 10, cyc);
            if (i < 8) pulse_next;
        end
        exp = (9 * 65025) % 65536;
        n_cmp++; if (out2[10] !== 1'b1) begin n_bad++; $display("FAIL ovf_finish got %b want 1", out2[10]); end
        n_cmp++; if (out2[11] !== 1'b1) begin n_bad++; $display("FAIL ovf_carry got %b want 1", out2[11]); end
        n_cmp++; if (out0[11] !== 1'b0) begin n_bad++; $display("FAIL wide_carry got %b want 0", out0[11]); end
        for (int k = 0; k < 16; k++) exp_q.push_back(exp[k]);
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out2[9] !== e) begin n_bad++; $display("FAIL ovf_bit%0d got %b want %b", k, out2[9], e); end
            pulse_shift;
        end
        n_cmp++; if (out2[9] !== 1'b0) begin n_bad++; $display("FAIL ovf_drained got %b want 0", out2[9]); end
    endtask

    task automatic test_restart;
        int cyc, exp;
        bit e;
        do_reset;
        pulse_start;
        send_bits(8'd100, 8'd100, 8);
        wait_flag(0, 8, cyc);
        pulse_next;
        send_bits(8'hFF, 8'hFF, 3);
        pulse_start;
        n_cmp++; if (out1[10] !== 1'b0) begin n_bad++; $display("FAIL restart_finish_clr got %b want 0", out1[10]); end
        exp = 0;
        for (int i = 0; i < 9; i++) begin
            send_bits(8'(i + 1), 8'd5, 8);
            exp += (i + 1) * 5;
            wait_flag(0, i < 8 ? 8 : 10, cyc);
            if (i < 8) pulse_next;
        end
        n_cmp++; if (out0[10] !== 1'b1) begin n_bad++; $display("FAIL restart_finish got %b want 1", out0[10]); end
        for (int k = 0; k < 20; k++) exp_q.push_back(exp[k]);
        for (int k = 0; k < 20; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out0[9] !== e) begin n_bad++; $display("FAIL restart_bit%0d got %b want %b", k, out0[9], e); end
            pulse_shift;
        end
    endtask

    task automatic test_shift_hold;
        int cyc, exp;
        bit e;
        do_reset;
        pulse_start;
        sa = 1; sb = 1; sh = 1;
        repeat (5) tick;
        sh = 0; sa = 0; sb = 0;
        repeat (2) tick;
        pulse_next;
        send_bits(8'h05, 8'h03, 7);
        pulse_next;
        wait_flag(1, 10, cyc);
        exp = 8'h85 * 8'h83;
        n_cmp++; if (out1[10] !== 1'b1) begin n_bad++; $display("FAIL hold_finish got %b want 1", out1[10]); end
        for (int k = 0; k < 20; k++) exp_q.push_back(exp[k]);
        for (int k = 0; k < 20; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (out1[9] !== e) begin n_bad++; $display("FAIL hold_bit%0d got %b want %b", k, out1[9], e); end
            pulse_shift;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_full_run;
        test_single;
        test_overflow;
        test_restart;
        test_shift_hold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/my_chip.md
Name: my_chip

Overview:
- Bit-serial multiply-accumulate (MAC) chip with a 12-bit pin-style interface.
- Operand pairs A and B (8-bit each) are shifted in MSB first, multiplied with a shift-add multiplier, and summed into a 20-bit accumulator.
- After NUM_MACS products, the accumulator is shifted out LSB first.
- Top-level tapeout block; all I/O goes through io_in/io_out.

Parameters:
- WIDTH, 8: operand width in bits.
- ACC_WIDTH, 20: accumulator width in bits.
- NUM_MACS, 9: number of products accumulated before finish.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_in  input  12
  - [11] start; [10] shiftA; [9] shiftB; [8] shift; [7] do_next.
  - [6:0] unused and ignored.
- io_out  output  12
  - [11] mac_carry_out; [10] finish; [9] shiftout; [8] end_mul.
  - [7:0] tied to 0.

Behaviour:
- Reset (async, active-high): state=IDLE; A, B, product, accumulator, carry, bit and MAC counters and shift_d all 0. All io_out bits are 0.
- Shift strobe:
  - shift_rise = shift & ~shift_d, with shift_d a registered copy of shift.
  - Only rising edges act; level length is irrelevant (the bench holds shift for 2 cycles).
- States:
  - IDLE
    - start=1 → clear accumulator, carry, MAC count; go to LOAD.
  - LOAD
    - Each shift_rise: A <= {A[6:0], shiftA}; B <= {B[6:0], shiftB}; bit count +1.
    - After the 8th bit → MUL, with product cleared.
  - MUL
    - Exactly WIDTH cycles of shift-add, one partial product per cycle.
    - Then accumulator += zero-extended 16-bit product, modulo 2^20.
    - A carry out of bit 19 sets sticky mac_carry_out.
    - MAC count +1.
    - If MAC count now equals NUM_MACS → DONE; else → WAIT.
  - WAIT
    - end_mul=1.
    - do_next=1 → LOAD, with bit count cleared.
    - shift pulses are ignored while in WAIT.
  - DONE
    - finish=1; shiftout = accumulator[0].
    - Each shift_rise shifts the accumulator right by 1, inserting 0.
    - After 20 rises, shiftout reads the full result LSB first (bit i sampled before the i-th rise).
    - Further rises yield 0.
- end_mul: registered, high only in WAIT.
- finish: registered, high only in DONE.
- mac_carry_out: sticky; cleared by start or reset.
- start=1 in any state restarts: clears accumulator, carry and counters; go to LOAD. This takes priority over all other inputs that cycle.
- do_next is ignored outside WAIT. start is ignored while held, beyond the restart it causes.
- Simultaneous shift_rise and do_next in WAIT: do_next wins; the shift is not captured.
- Latency:
  - Last operand bit to end_mul/finish: WIDTH+2 cycles.
  - do_next to LOAD: 1 cycle.

Optional Feature:
- Macro: SYNC_INPUTS_EN.
- Defined: io_in[11:7] pass through a 2-flop synchronizer before use. Every input response is delayed by 2 cycles; functional results are unchanged.
- Undefined: io_in is used directly (registered only by shift_d edge detection).

Test Plan:
- Reset for 2 cycles → all io_out = 0, state IDLE; shift pulses have no effect before start.
- Full run:
  - start, then 9 pairs (i+2, i+3) for i=0..8, each followed by do_next.
  - → end_mul pulses after each of pairs 1-8; finish after the 9th product.
  - 20 shift-outs give 438; mac_carry_out=0.
- Single pair 255×255 with NUM_MACS=1 → finish, result 65025, carry 0.
- Overflow: NUM_MACS pairs of 255×255 with ACC_WIDTH=16 → mac_carry_out=1; low bits = sum mod 2^16.
- start asserted mid-LOAD after 3 bits → accumulator and counters cleared; next 8 bits load a fresh operand; final result excludes prior data.
- Shift held high 5 cycles in LOAD → only 1 bit captured; do_next in LOAD or MUL → ignored.
